// File: rtl/data_sync_tx_sched_if.sv
// data_sync_tx_sched_if: requester handshake plus the bus driven toward the destination synchronizer.
interface data_sync_tx_sched_if #(
    parameter int D_WIDTH  = 8,
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = 2
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*D_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     sync_enable;
    logic [D_WIDTH-1:0]       sync_bus;
    logic [ID_WIDTH-1:0]      sync_id;
    logic                     busy;
    logic                     xfer_done;
    modport master (input req_valid, req_data,
                    output req_ready, sync_enable, sync_bus, sync_id, busy, xfer_done);
    modport slave  (output req_valid, req_data,
                    input req_ready, sync_enable, sync_bus, sync_id, busy, xfer_done);
endinterface

// File: rtl/data_sync_tx_sched.sv
// data_sync_tx_sched: round-robin scheduler sharing one level-enable CDC bus among requesters,
// holding enable for a programmed time and then a programmed low gap per word.
module data_sync_tx_sched #(
    parameter int D_WIDTH   = 8,
    parameter int N_REQ     = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CNT_WIDTH-1:0] i_hold_cycles,
    input  logic [CNT_WIDTH-1:0] i_gap_cycles,
    data_sync_tx_sched_if.master bus_if
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    state_t               r_state, w_state;
    logic [ID_WIDTH-1:0]  r_ptr, w_ptr, w_win, r_id, w_id;
    logic                 w_any;
    logic [CNT_WIDTH-1:0] r_hcnt, w_hcnt, r_gcnt, w_gcnt, r_gcfg, w_gcfg;
    logic [D_WIDTH-1:0]   r_bus, w_bus;
    logic [N_REQ-1:0]     r_ready, w_ready;
    logic                 r_en, w_en, r_done, w_done, r_busy;

    // Scan from farthest to nearest so the nearest valid index after ptr wins.
    always_comb begin
        logic [ID_WIDTH-1:0] j;
        j     = '0;
        w_win = r_ptr;
        w_any = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = ID_WIDTH'((int'(r_ptr) + k) % N_REQ);
            if (bus_if.req_valid[j]) begin
                w_win = j;
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_hcnt  = r_hcnt;
        w_gcnt  = r_gcnt;
        w_gcfg  = r_gcfg;
        w_bus   = r_bus;
        w_id    = r_id;
        w_ready = '0;
        w_en    = r_en;
        w_done  = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_state = HOLD;
                w_ptr   = w_win;
                w_id    = w_win;
                w_bus   = bus_if.req_data[w_win*D_WIDTH +: D_WIDTH];
                w_ready = N_REQ'(1) << w_win;
                w_en    = 1'b1;
                w_hcnt  = (i_hold_cycles == '0) ? CNT_WIDTH'(1) : i_hold_cycles;
                w_gcfg  = (i_gap_cycles == '0) ? CNT_WIDTH'(1) : i_gap_cycles;
            end
            HOLD: begin
                w_hcnt = r_hcnt - 1'b1;
                if (r_hcnt <= CNT_WIDTH'(1)) begin
                    w_state = GAP;
                    w_en    = 1'b0;
                    w_gcnt  = r_gcfg;
                    w_done  = (r_gcfg == CNT_WIDTH'(1));
                end
            end
            GAP: begin
                w_gcnt = r_gcnt - 1'b1;
                w_done = (r_gcnt == CNT_WIDTH'(2));
                if (r_gcnt <= CNT_WIDTH'(1)) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_ptr   <= ID_WIDTH'(N_REQ - 1);
            r_hcnt  <= '0;
            r_gcnt  <= '0;
            r_gcfg  <= '0;
            r_bus   <= '0;
            r_id    <= '0;
            r_ready <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_hcnt  <= w_hcnt;
            r_gcnt  <= w_gcnt;
            r_gcfg  <= w_gcfg;
            r_bus   <= w_bus;
            r_id    <= w_id;
            r_ready <= w_ready;
            r_en    <= w_en;
            r_done  <= w_done;
            r_busy  <= (w_state != IDLE);
        end
    end

    assign bus_if.req_ready   = r_ready;
    assign bus_if.sync_enable = r_en;
    assign bus_if.sync_bus    = r_bus;
    assign bus_if.sync_id     = r_id;
    assign bus_if.busy        = r_busy;
    assign bus_if.xfer_done   = r_done;
endmodule

// File: tb/tb_data_sync_tx_sched.sv
// tb_data_sync_tx_sched: directed and random words against a transaction-level round-robin/timing model,
// plus a behavioural slow-clock 2-FF destination synchronizer for the end-to-end check.
module tb_data_sync_tx_sched;
    localparam int DW = 8, NR = 4, IW = 2, CW = 4;
    logic          CLK = 1'b0, RST = 1'b0, dclk = 1'b0, e2e = 1'b0;
    logic [CW-1:0] hold_cycles = '0, gap_cycles = '0;
    logic [2:0]    d_sr = '0;
    logic [DW-1:0] d_got[$], d_exp[$];
    int            checks = 0, errors = 0, last = NR - 1;

    data_sync_tx_sched_if #(.D_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) bif();
    data_sync_tx_sched #(.D_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .i_hold_cycles(hold_cycles), .i_gap_cycles(gap_cycles), .bus_if(bif));

    always #5 CLK = ~CLK;
    initial begin
        #7;
        forever #15 dclk = ~dclk;
    end

    // Destination side: 2-FF synchronizer, rising-edge pulse, bus capture on the pulse.
    always @(posedge dclk) begin
        d_sr <= {d_sr[1:0], bif.sync_enable};
        if (e2e && d_sr[1] && !d_sr[2]) d_got.push_back(bif.sync_bus);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int from, input logic [NR-1:0] m);
        logic [NR-1:0] t;
        for (int k = 1; k <= NR; k++) begin
            t = m >> ((from + k) % NR);
            if (t[0]) return (from + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, 32'(bif.sync_enable), 0);
        chk({tag, "_bus"}, 32'(bif.sync_bus), 0);
        chk({tag, "_id"}, 32'(bif.sync_id), 0);
        chk({tag, "_rdy"}, 32'(bif.req_ready), 0);
        chk({tag, "_busy"}, 32'(bif.busy), 0);
        chk({tag, "_done"}, 32'(bif.xfer_done), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic do_word(input logic [NR-1:0] mask, input int h, input int g, input logic [DW-1:0] d,
                           input bit mid_rst, output logic [DW-1:0] sent);
        logic [NR*DW-1:0] dv;
        int w, hh, gg;
        w  = rr(last, mask);
        hh = (h == 0) ? 1 : h;
        gg = (g == 0) ? 1 : g;
        for (int i = 0; i < NR; i++) dv[i*DW +: DW] = 8'($urandom);
        dv[w*DW +: DW] = d;
        sent = d;
        bif.req_valid = mask;
        bif.req_data  = dv;
        hold_cycles   = CW'(h);
        gap_cycles    = CW'(g);
        @(negedge CLK);
        last = w;
        chk("c1_en", 32'(bif.sync_enable), 1);
        chk("c1_bus", 32'(bif.sync_bus), 32'(d));
        chk("c1_id", 32'(bif.sync_id), 32'(w));
        chk("c1_rdy", 32'(bif.req_ready), 32'(1) << w);
        chk("c1_busy", 32'(bif.busy), 1);
        chk("c1_done", 32'(bif.xfer_done), 0);
        bif.req_valid = '0;
        hold_cycles   = CW'($urandom);
        gap_cycles    = CW'($urandom);
        if (mid_rst) begin
            @(negedge CLK);
            RST = 1'b0;
            #1;
            check_zero("rst_mid");
            last = NR - 1;
            @(negedge CLK);
            RST = 1'b1;
            return;
        end
        for (int c = 2; c <= hh + gg; c++) begin
            @(negedge CLK);
            chk("en", 32'(bif.sync_enable), 32'(c <= hh));
            chk("rdy", 32'(bif.req_ready), 0);
            chk("busy", 32'(bif.busy), 1);
            chk("done", 32'(bif.xfer_done), 32'(c == hh + gg));
            chk("bus_hold", 32'(bif.sync_bus), 32'(d));
            chk("id_hold", 32'(bif.sync_id), 32'(w));
        end
        @(negedge CLK);
        chk("idle_busy", 32'(bif.busy), 0);
        chk("idle_en", 32'(bif.sync_enable), 0);
        chk("idle_done", 32'(bif.xfer_done), 0);
        chk("idle_bus", 32'(bif.sync_bus), 32'(d));
    endtask

    initial begin
        logic [DW-1:0]    s;
        logic [NR*DW-1:0] dv;
        int w;
        bif.req_valid = '1;
        bif.req_data  = '0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RST = 1'b1;
        bif.req_valid = '0;
        @(negedge CLK);
        check_zero("post_reset");

        do_word(4'b0010, 3, 2, 8'hA5, 1'b0, s);
        do_word(4'b1111, 0, 0, 8'h3C, 1'b0, s);
        do_word(4'b1111, 4, 2, 8'h5A, 1'b0, s);
        do_word(4'b1111, 1, 1, 8'hC3, 1'b0, s);

        // All requesters continuously valid: grants rotate, one capture every three cycles.
        for (int i = 0; i < NR; i++) dv[i*DW +: DW] = 8'($urandom);
        bif.req_data  = dv;
        bif.req_valid = '1;
        hold_cycles   = 4'd1;
        gap_cycles    = 4'd1;
        for (int n = 0; n < 2 * NR; n++) begin
            w = rr(last, 4'b1111);
            @(negedge CLK);
            last = w;
            chk("rr_rdy", 32'(bif.req_ready), 32'(1) << w);
            chk("rr_id", 32'(bif.sync_id), 32'(w));
            chk("rr_bus", 32'(bif.sync_bus), 32'(dv[w*DW +: DW]));
            chk("rr_en", 32'(bif.sync_enable), 1);
            @(negedge CLK);
            chk("rr_done", 32'(bif.xfer_done), 1);
            chk("rr_rdy0", 32'(bif.req_ready), 0);
            @(negedge CLK);
            chk("rr_idle", 32'(bif.busy), 0);
            if (n == 2 * NR - 1) bif.req_valid = '0;
        end
        @(negedge CLK);

        do_word(4'b0100, 5, 2, 8'h77, 1'b1, s);
        do_word(4'b1111, 2, 1, 8'h99, 1'b0, s);

        for (int n = 0; n < 20; n++)
            do_word(4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 5),
                    8'($urandom), 1'b0, s);

        repeat (10) @(negedge CLK);
        e2e = 1'b1;
        for (int n = 0; n < 8; n++) begin
            do_word(4'($urandom_range(1, 15)), 12, 12, 8'($urandom), 1'b0, s);
            d_exp.push_back(s);
        end
        repeat (20) @(negedge CLK);
        e2e = 1'b0;
        chk("e2e_pulses", 32'(d_got.size()), 8);
        for (int i = 0; i < 8; i++)
            chk("e2e_data", (i < d_got.size()) ? 32'(d_got[i]) : 32'hFFFF_FFFF, 32'(d_exp[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
